mem_req_arbiter: RTL and testbench

//  Shares the single external-memory refill path between NUM_REQ block-miss requesters (demand miss handler, next-line prefetcher).

---
 rtl/icache_defs.sv | 27 ++
 rtl/arb_pick.sv | 45 ++++
 rtl/mem_req_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_defs.sv
// -----------------------------------------------------------------------------
// icache_defs
//   Definitions shared by the instruction-cache refill blocks.
//   - ADDR_WIDTH     : default block-address width (matches memory_controller)
//   - arb_state_t    : mem_req_arbiter FSM encoding (IDLE=0, ISSUE=1, WAIT=2;
//                      3 is illegal and recovers to IDLE)
//   - REQ_DEMAND / REQ_PREFETCH : requester index constants
//   - idx_width()    : width of an index into n requesters (never below 1)
// -----------------------------------------------------------------------------
package icache_defs;

    localparam int ADDR_WIDTH   = 16;

    localparam int REQ_DEMAND   = 0;
    localparam int REQ_PREFETCH = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
//   Combinational request picker. Scans the valid vector starting at i_start,
//   wrapping modulo N, and returns the first set requester.
//   Ports:
//     i_valid  [N]      requests pending
//     i_start  [IDX_W]  index where the scan begins (must be < N)
//     o_onehot [N]      one-hot winner (all zero when nothing pending)
//     o_index  [IDX_W]  winner index (0 when nothing pending)
//     o_any             at least one request pending
//   A start of 0 gives fixed priority with the lowest index winning.
// -----------------------------------------------------------------------------
module arb_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     i_valid,
    input  logic [IDX_W-1:0] i_start,
    output logic [N-1:0]     o_onehot,
    output logic [IDX_W-1:0] o_index,
    output logic             o_any
);

    function automatic int wrap_idx(input int start, input int off);
        int s;
        s = start + off;
        return (s >= N) ? (s - N) : s;
    endfunction

    always_comb begin
        // NOTE: every output gets a default before the search loop so that no
        // path through the block leaves a value unassigned (no latch inferred).
        o_onehot = '0;
        o_index  = '0;
        o_any    = 1'b0;
        for (int off = 0; off < N; off++) begin
            if (!o_any && i_valid[wrap_idx(int'(i_start), off)]) begin
                o_any                                 = 1'b1;
                o_onehot[wrap_idx(int'(i_start), off)] = 1'b1;
                o_index                               = IDX_W'(wrap_idx(int'(i_start), off));
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// mem_req_arbiter
//   Shares the single external-memory refill path between NUM_REQ block-miss
//   requesters (index 0 = demand miss, 1 = next-line prefetcher). One pending
//   request is accepted, its block address is presented to memory_controller
//   with the initiate/valid handshake, and the grant is held until the
//   controller reports the whole block received.
//
//   Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration (scan
//   starts one past the last grant). Without it, fixed priority, lowest index
//   wins, and no rotation pointer exists.
//
//   Ports:
//     clk, arst_n            clock, asynchronous active-low reset
//     i_halt                 freeze all state/counter/pointer updates
//     i_req_valid[NUM_REQ]   per-requester request pending
//     i_req_addr             packed addresses, requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//     o_req_ready[NUM_REQ]   one-hot accept, combinational, in the grant cycle
//     o_done[NUM_REQ]        one-hot one-cycle pulse: granted block received
//     o_block_addr           -> ctrl i_block_addr
//     o_block_addr_valid     -> ctrl i_block_addr_valid
//     o_initiate_req         -> ctrl i_initiate_req
//     o_ir_valid             -> ctrl i_ir_valid
//     i_ir_ready             <- ctrl o_ir_ready
//     i_mem_data_received    <- ctrl o_mem_data_received
//     i_mem_data_rcvd_valid  <- ctrl o_mem_data_rcvd_valid
//     o_grant_id             index of the current / last grant
//     o_busy                 FSM not idle
//     o_timeout              sticky watchdog error (TIMEOUT_CYCLES=0 disables)
// -----------------------------------------------------------------------------
module mem_req_arbiter
    import icache_defs::*;
#(
    parameter  int ADDR_WIDTH     = icache_defs::ADDR_WIDTH,
    parameter  int NUM_REQ        = 2,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int GID_W          = idx_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic                          i_halt,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic [NUM_REQ-1:0]            o_done,
    output logic [ADDR_WIDTH-1:0]         o_block_addr,
    output logic                          o_block_addr_valid,
    output logic                          o_initiate_req,
    output logic                          o_ir_valid,
    input  logic                          i_ir_ready,
    input  logic                          i_mem_data_received,
    input  logic                          i_mem_data_rcvd_valid,
    output logic [GID_W-1:0]              o_grant_id,
    output logic                          o_busy,
    output logic                          o_timeout
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    arb_state_t             r_state;
    arb_state_t             w_next_state;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [GID_W-1:0]       r_grant;
    logic [NUM_REQ-1:0]     r_done;
    logic [CNT_W-1:0]       r_wd_cnt;
    logic                   r_timeout;

    logic [GID_W-1:0]       w_start;
    logic [NUM_REQ-1:0]     w_pick_onehot;
    logic [GID_W-1:0]       w_pick_idx;
    logic                   w_pick_any;
    logic                   w_grant_now;
    logic                   w_rcvd;
    logic [ADDR_WIDTH-1:0]  w_pick_addr;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
    // The rotation pointer is the last-grant register itself: both reset to 0
    // and both change only on a grant, so a separate copy would be redundant.
    assign w_start = (r_grant == GID_W'(NUM_REQ - 1)) ? '0 : r_grant + GID_W'(1);
`else
    assign w_start = '0;
`endif

    arb_pick #(
        .N     (NUM_REQ),
        .IDX_W (GID_W)
    ) u_pick (
        .i_valid  (i_req_valid),
        .i_start  (w_start),
        .o_onehot (w_pick_onehot),
        .o_index  (w_pick_idx),
        .o_any    (w_pick_any)
    );

    assign w_pick_addr = i_req_addr[int'(w_pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_grant_now = (r_state == ST_IDLE) && !i_halt && w_pick_any;
    assign w_rcvd      = i_mem_data_received && i_mem_data_rcvd_valid;

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples values from before the edge, independent of block ordering.
        if (!arst_n) begin
            r_state <= ST_IDLE;
        end else if (!i_halt) begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state       = r_state;
        o_req_ready        = '0;
        o_initiate_req     = 1'b0;
        o_ir_valid         = 1'b0;
        o_block_addr_valid = 1'b0;
        o_block_addr       = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_now) begin
                    o_req_ready  = w_pick_onehot;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Held through i_halt: the controller is frozen with us.
                o_initiate_req     = 1'b1;
                o_ir_valid         = 1'b1;
                o_block_addr_valid = 1'b1;
                o_block_addr       = r_addr;
                if (!i_halt && i_ir_ready) begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!i_halt && w_rcvd) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Address / grant / completion registers
    // -------------------------------------------------------------------------
    // o_done is a register like everything else, so a halt in the cycle it is
    // high stretches it until the halt drops.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_addr  <= '0;
            r_grant <= GID_W'(REQ_DEMAND);
            r_done  <= '0;
        end else if (!i_halt) begin
            r_done <= '0;
            if (w_grant_now) begin
                r_addr  <= w_pick_addr;
                r_grant <= w_pick_idx;
            end
            if ((r_state == ST_WAIT) && w_rcvd) begin
                r_done <= NUM_REQ'(1) << r_grant;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Watchdog: counts ISSUE/WAIT cycles since the grant and flags a transfer
    // that has not completed within TIMEOUT_CYCLES. Detection only; the FSM
    // keeps waiting.
    // -------------------------------------------------------------------------
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wdog
            logic [CNT_W-1:0] w_cnt_inc;
            assign w_cnt_inc = r_wd_cnt + CNT_W'(1);

            always_ff @(posedge clk or negedge arst_n) begin
                if (!arst_n) begin
                    r_wd_cnt  <= '0;
                    r_timeout <= 1'b0;
                end else if (!i_halt) begin
                    if (w_grant_now) begin
                        r_wd_cnt <= '0;
                    end else if (((r_state == ST_ISSUE) || (r_state == ST_WAIT))
                                 && (r_wd_cnt != CNT_MAX)) begin
                        r_wd_cnt <= w_cnt_inc;
                        if (w_cnt_inc == CNT_MAX) begin
                            r_timeout <= 1'b1;
                        end
                    end
                end
            end
        end else begin : g_no_wdog
            assign r_wd_cnt  = '0;
            assign r_timeout = 1'b0;
        end
    endgenerate

    assign o_done     = r_done;
    assign o_grant_id = r_grant;
    assign o_busy     = (r_state != ST_IDLE);
    assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_req_arbiter
//   Directed bench for mem_req_arbiter (ADDR_WIDTH=16, NUM_REQ=2,
//   TIMEOUT_CYCLES=8). Inputs change 1 time unit after the rising edge;
//   outputs are compared 2 time units after the rising edge.
//   Expected grant order follows ARB_ROUND_ROBIN_EN when defined.
// -----------------------------------------------------------------------------
module tb_mem_req_arbiter;

    logic        clk;
    logic        arst_n;
    logic        i_halt;
    logic [1:0]  i_req_valid;
    logic [31:0] i_req_addr;
    logic [1:0]  o_req_ready;
    logic [1:0]  o_done;
    logic [15:0] o_block_addr;
    logic        o_block_addr_valid;
    logic        o_initiate_req;
    logic        o_ir_valid;
    logic        i_ir_ready;
    logic        i_mem_data_received;
    logic        i_mem_data_rcvd_valid;
    logic        o_grant_id;
    logic        o_busy;
    logic        o_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_first;
    int exp_second;
    logic [15:0] exp_first_addr;
    logic [15:0] exp_second_addr;

    mem_req_arbiter #(
        .ADDR_WIDTH     (16),
        .NUM_REQ        (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk                   (clk),
        .arst_n                (arst_n),
        .i_halt                (i_halt),
        .i_req_valid           (i_req_valid),
        .i_req_addr            (i_req_addr),
        .o_req_ready           (o_req_ready),
        .o_done                (o_done),
        .o_block_addr          (o_block_addr),
        .o_block_addr_valid    (o_block_addr_valid),
        .o_initiate_req        (o_initiate_req),
        .o_ir_valid            (o_ir_valid),
        .i_ir_ready            (i_ir_ready),
        .i_mem_data_received   (i_mem_data_received),
        .i_mem_data_rcvd_valid (i_mem_data_rcvd_valid),
        .o_grant_id            (o_grant_id),
        .o_busy                (o_busy),
        .o_timeout             (o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic rcvd(input logic v);
        i_mem_data_received   = v;
        i_mem_data_rcvd_valid = v;
    endtask

    // Guard against a stuck simulation.
    initial begin
        #100000;
        $display("FAIL sim_time_limit: got expired expected finish");
        $fatal(1);
    end

    initial begin
        arst_n      = 1'b0;
        i_halt      = 1'b0;
        i_req_valid = 2'b00;
        i_req_addr  = '0;
        i_ir_ready  = 1'b0;
        rcvd(1'b0);

        // ---------------- reset state ----------------
        #12;
        check("rst_busy",    32'(o_busy), 32'h0);
        check("rst_done",    32'(o_done), 32'h0);
        check("rst_grant",   32'(o_grant_id), 32'h0);
        check("rst_hs",      32'({o_initiate_req, o_ir_valid, o_block_addr_valid}), 32'h0);
        check("rst_addr",    32'(o_block_addr), 32'h0);
        check("rst_timeout", 32'(o_timeout), 32'h0);
        check("rst_ready",   32'(o_req_ready), 32'h0);
        step();
        arst_n = 1'b1;

        // ---------------- 1: single request ----------------
        i_req_valid       = 2'b01;
        i_req_addr[15:0]  = 16'h1234;
        i_ir_ready        = 1'b1;
        settle();
        check("t1_ready", 32'(o_req_ready), 32'h1);
        check("t1_idle_busy", 32'(o_busy), 32'h0);
        step();
        i_req_valid = 2'b00;
        settle();
        check("t1_issue_addr", 32'(o_block_addr), 32'h1234);
        check("t1_issue_hs", 32'({o_initiate_req, o_ir_valid, o_block_addr_valid}), 32'h7);
        check("t1_ready_gone", 32'(o_req_ready), 32'h0);
        step();
        settle();
        check("t1_wait_hs", 32'({o_initiate_req, o_ir_valid, o_block_addr_valid}), 32'h0);
        check("t1_wait_addr", 32'(o_block_addr), 32'h0);
        check("t1_wait_busy", 32'(o_busy), 32'h1);
        rcvd(1'b1);
        settle();
        check("t1_done_early", 32'(o_done), 32'h0);
        step();
        rcvd(1'b0);
        settle();
        check("t1_done", 32'(o_done), 32'h1);
        check("t1_idle_again", 32'(o_busy), 32'h0);
        step();
        settle();
        check("t1_done_pulse", 32'(o_done), 32'h0);

        // ---------------- 2: simultaneous requests ----------------
`ifdef ARB_ROUND_ROBIN_EN
        exp_first = 1;
`else
        exp_first = 0;
`endif
        exp_second      = 1 - exp_first;
        exp_first_addr  = (exp_first  == 0) ? 16'h0010 : 16'h0020;
        exp_second_addr = (exp_second == 0) ? 16'h0010 : 16'h0020;
        i_req_addr  = {16'h0020, 16'h0010};
        i_req_valid = 2'b11;
        settle();
        check("t2_ready_first", 32'(o_req_ready), 32'(1 << exp_first));
        step();
        i_req_valid[exp_first] = 1'b0;
        settle();
        check("t2_addr_first", 32'(o_block_addr), 32'(exp_first_addr));
        check("t2_gid_first", 32'(o_grant_id), 32'(exp_first));
        step();
        rcvd(1'b1);
        step();
        rcvd(1'b0);
        settle();
        check("t2_done_first", 32'(o_done), 32'(1 << exp_first));
        check("t2_ready_b2b", 32'(o_req_ready), 32'(1 << exp_second));
        step();
        i_req_valid = 2'b00;
        settle();
        check("t2_addr_second", 32'(o_block_addr), 32'(exp_second_addr));
        check("t2_gid_second", 32'(o_grant_id), 32'(exp_second));
        step();
        rcvd(1'b1);
        step();
        rcvd(1'b0);
        settle();
        check("t2_done_second", 32'(o_done), 32'(1 << exp_second));
        step();

        // ---------------- 3: ISSUE held while controller not ready ----------------
        i_ir_ready       = 1'b0;
        i_req_addr[15:0] = 16'h0abc;
        i_req_valid      = 2'b01;
        settle();
        check("t3_ready", 32'(o_req_ready), 32'h1);
        step();
        i_req_valid = 2'b00;
        settle();
        for (int k = 0; k < 5; k++) begin
            check("t3_hold", 32'({o_initiate_req, o_ir_valid, o_block_addr_valid, o_block_addr}),
                  32'({3'b111, 16'h0abc}));
            step();
            settle();
        end
        i_ir_ready = 1'b1;
        settle();
        check("t3_still_issue", 32'({o_ir_valid, o_block_addr}), 32'({1'b1, 16'h0abc}));
        step();
        settle();
        check("t3_wait", 32'({o_busy, o_ir_valid}), 32'h2);
        rcvd(1'b1);
        step();
        rcvd(1'b0);
        settle();
        check("t3_done", 32'(o_done), 32'h1);
        check("t3_no_timeout", 32'(o_timeout), 32'h0);
        step();

        // ---------------- 4: halt ----------------
        i_halt           = 1'b1;
        i_req_addr[15:0] = 16'h0100;
        i_req_valid      = 2'b01;
        settle();
        check("t4_ready_halted", 32'(o_req_ready), 32'h0);
        step();
        settle();
        check("t4_no_grant", 32'(o_busy), 32'h0);
        i_halt = 1'b0;
        settle();
        check("t4_ready", 32'(o_req_ready), 32'h1);
        step();
        i_req_valid = 2'b00;
        step();
        i_halt = 1'b1;
        rcvd(1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            settle();
            check("t4_frozen", 32'({o_busy, o_done}), 32'h4);
        end
        i_halt = 1'b0;
        step();
        rcvd(1'b0);
        settle();
        check("t4_done", 32'({o_busy, o_done}), 32'h1);
        check("t4_no_timeout", 32'(o_timeout), 32'h0);
        step();

        // ---------------- 5: watchdog ----------------
        i_req_addr[15:0] = 16'h0200;
        i_req_valid      = 2'b01;
        step();
        i_req_valid = 2'b00;
        for (int k = 0; k < 7; k++) begin
            step();
        end
        settle();
        check("t5_before_limit", 32'(o_timeout), 32'h0);
        step();
        settle();
        check("t5_timeout", 32'(o_timeout), 32'h1);
        check("t5_still_wait", 32'({o_busy, o_ir_valid}), 32'h2);
        step();
        step();
        step();
        settle();
        check("t5_sticky", 32'({o_timeout, o_busy}), 32'h3);

        // ---------------- 6: reset during WAIT ----------------
        arst_n = 1'b0;
        settle();
        check("t6_busy", 32'(o_busy), 32'h0);
        check("t6_timeout", 32'(o_timeout), 32'h0);
        check("t6_outs", 32'({o_done, o_initiate_req, o_ir_valid, o_block_addr_valid, o_block_addr}), 32'h0);
        rcvd(1'b1);
        step();
        arst_n = 1'b1;
        step();
        rcvd(1'b0);
        settle();
        check("t6_no_done", 32'({o_busy, o_done}), 32'h0);
        i_req_addr[15:0] = 16'h0300;
        i_req_valid      = 2'b01;
        settle();
        check("t6_ready", 32'(o_req_ready), 32'h1);
        step();
        i_req_valid = 2'b00;
        settle();
        check("t6_addr", 32'(o_block_addr), 32'h0300);
        step();
        rcvd(1'b1);
        step();
        rcvd(1'b0);
        settle();
        check("t6_done", 32'(o_done), 32'h1);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
